pixel_frame_streamer: RTL and testbench
=======================================

Name: pixel_frame_streamer

Overview:
- Responder side of the pixel request handshake used by facial_detection_ip.
- Buffers camera pixels written on the OS clock domain into a small synchronous FIFO.
- Presents one pixel per asserted pixel_request.
- Tracks raster coordinates, end-of-row and end-of-frame so the OS side stays aligned with the detector's own ori_x/ori_y iteration.

Parameters:
- DATA_WIDTH_12, 12, pixel and coordinate width.
- FRAME_ORIGINAL_CAMERA_WIDTH, 100, pixels per row.
- FRAME_ORIGINAL_CAMERA_HEIGHT, 24, rows per frame.
- FIFO_DEPTH, 16, pixel buffer entries; must be a power of 2.
- FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH).
- FRAME_COUNT_WIDTH, 8, width of the frame counter.

Ports:
- clk_os  in  1  OS-side clock; the block's only clock.
- reset_os  in  1  asynchronous, active-low reset.
- frame_start  in  1  synchronous flush; realigns to pixel (0,0).
- wr_en  in  1  camera pixel write strobe.
- wr_pixel  in  DATA_WIDTH_12  camera pixel data.
- o_full  out  1  FIFO full.
- o_fill_level  out  FIFO_ADDR_WIDTH+1  current number of FIFO entries.
- pixel_request  in  1  request from facial_detection_ip (its o_pixel_request).
- o_pixel  out  DATA_WIDTH_12  pixel delivered to the detector's pixel input.
- o_pixel_valid  out  1  one-cycle strobe: o_pixel was served for the last request.
- o_x  out  DATA_WIDTH_12  column of the pixel on o_pixel.
- o_y  out  DATA_WIDTH_12  row of the pixel on o_pixel.
- o_end_row  out  1  pixel on o_pixel is the last of its row.
- o_end_frame  out  1  pixel on o_pixel is the last of the frame.
- o_frame_count  out  FRAME_COUNT_WIDTH  number of completed frames; wraps.
- o_underrun  out  1  sticky: a request arrived while the FIFO was empty.
- o_overflow  out  1  sticky: a write arrived while the FIFO was full, with no read in the same cycle.

Behaviour:
- Reset (reset_os low, asynchronous): all outputs 0. FIFO empty, so o_fill_level=0 and o_full=0. Next coordinate is (0,0).
- Latency: pixel_request sampled high at edge N → o_pixel, o_x, o_y, o_end_row, o_end_frame and o_pixel_valid are registered at edge N. They are valid during cycle N+1, matching the detector's r_pixel_recieve sampling.
- o_pixel_valid is high exactly one cycle per sampled request. It is 0 on the next edge unless pixel_request is still high (back-to-back requests give consecutive strobes).
- o_pixel, o_x and o_y hold their last values when no request is sampled.
- Request with FIFO non-empty: pop the head entry onto o_pixel.
- Request with FIFO empty:
  - o_pixel=0 and o_underrun is set.
  - o_pixel_valid still pulses and the coordinates still advance, so the detector's ori_x/ori_y stay aligned.
  - No write bypass: a write in the same cycle is stored, not forwarded.
- Coordinate advance per served request:
  - x increments; at WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0 and o_frame_count increments (modulo 2^FRAME_COUNT_WIDTH).
  - o_end_row=1 when o_x=WIDTH-1; o_end_frame=1 when additionally o_y=HEIGHT-1.
- FIFO write:
  - Accepted when not full, or when full with a pop in the same cycle (the slot is freed).
  - Otherwise dropped and o_overflow is set.
  - o_fill_level = writes accepted − pops; it never exceeds FIFO_DEPTH.
- frame_start:
  - Has priority over wr_en and pixel_request in the same cycle.
  - Flushes the FIFO and zeroes next coordinates, o_x/o_y, o_end_*, o_pixel_valid and both sticky flags.
  - o_frame_count is not cleared.
- No internal FSM beyond the FIFO and counters. The states are implied: IDLE (no request), SERVE (pop), STARVE (empty request).

Decomposition:
- Shared package (face_detect_pkg): DATA_WIDTH_8/12/16 and frame width/height defaults.
- One sub-module: sync_fifo (parameterised width/depth).
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty, count.
  - Supports simultaneous read and write when full.
- The streamer owns the request logic, coordinate counters and flags.

Test Plan:
- Reset, then write 3 pixels (0x011, 0x022, 0x033), then 3 single-cycle requests → o_pixel 0x011/0x022/0x033 one cycle after each request; o_x 0,1,2; o_y 0; o_fill_level 3→0.
- Write 100 pixels, then hold pixel_request high for 100 cycles (keep the FIFO refilled) → o_end_row only on o_x=99; next request gives o_x=0, o_y=1.
- Stream 2400 pixels → o_end_frame once at (99,23); o_frame_count 0→1; coordinates wrap to (0,0).
- Request with FIFO empty → o_pixel=0, o_pixel_valid=1, o_underrun=1 (stays set); o_x advances by 1.
- Fill 16 entries, write again with no read → o_overflow=1, level stays 16. Then write and request in the same cycle → write accepted, level stays 16.
- Mid-frame at (37,5) with 4 entries buffered, assert frame_start together with wr_en and pixel_request → level 0, flags 0, next served pixel at (0,0), o_frame_count unchanged.
- Drive reset_os low asynchronously mid-stream → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/face_detect_pkg.sv
// Shared widths and camera frame geometry for the facial-detection datapath.
package face_detect_pkg;
   localparam int unsigned DATA_WIDTH_8  = 8;
   localparam int unsigned DATA_WIDTH_12 = 12;
   localparam int unsigned DATA_WIDTH_16 = 16;

   localparam int unsigned FRAME_ORIGINAL_CAMERA_WIDTH  = 100;
   localparam int unsigned FRAME_ORIGINAL_CAMERA_HEIGHT = 24;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a write is accepted while full if a read frees a slot in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH      = 12,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count
);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  wr_do;
   logic                  rd_do;

   assign full    = (count_q == (ADDR_WIDTH+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign rd_do = rd_en && !empty;
   assign wr_do = wr_en && (!full || rd_do);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_do) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         if (rd_do) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
         if (wr_do && !rd_do)      count_d = count_q + (ADDR_WIDTH+1)'(1);
         else if (rd_do && !wr_do) count_d = count_q - (ADDR_WIDTH+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only observable through count.
   always_ff @(posedge clk) begin
      if (wr_do && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/pixel_frame_streamer.sv
// Responder for the detector's pixel request: serves buffered camera pixels with raster coordinates.
module pixel_frame_streamer
   import face_detect_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_12                = face_detect_pkg::DATA_WIDTH_12,
   parameter int unsigned FRAME_ORIGINAL_CAMERA_WIDTH  = face_detect_pkg::FRAME_ORIGINAL_CAMERA_WIDTH,
   parameter int unsigned FRAME_ORIGINAL_CAMERA_HEIGHT = face_detect_pkg::FRAME_ORIGINAL_CAMERA_HEIGHT,
   parameter int unsigned FIFO_DEPTH                   = 16,
   parameter int unsigned FIFO_ADDR_WIDTH              = 4,
   parameter int unsigned FRAME_COUNT_WIDTH            = 8
) (
   input  logic                         clk_os,
   input  logic                         reset_os,
   input  logic                         frame_start,
   input  logic                         wr_en,
   input  logic [DATA_WIDTH_12-1:0]     wr_pixel,
   output logic                         o_full,
   output logic [FIFO_ADDR_WIDTH:0]     o_fill_level,
   input  logic                         pixel_request,
   output logic [DATA_WIDTH_12-1:0]     o_pixel,
   output logic                         o_pixel_valid,
   output logic [DATA_WIDTH_12-1:0]     o_x,
   output logic [DATA_WIDTH_12-1:0]     o_y,
   output logic                         o_end_row,
   output logic                         o_end_frame,
   output logic [FRAME_COUNT_WIDTH-1:0] o_frame_count,
   output logic                         o_underrun,
   output logic                         o_overflow
);

   localparam logic [DATA_WIDTH_12-1:0] X_LAST = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_WIDTH - 1);
   localparam logic [DATA_WIDTH_12-1:0] Y_LAST = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_HEIGHT - 1);

   logic [DATA_WIDTH_12-1:0]     fifo_rd_data;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [FIFO_ADDR_WIDTH:0]     fifo_count;
   logic                         pop;
   logic                         push;

   logic [DATA_WIDTH_12-1:0]     x_q, x_d;
   logic [DATA_WIDTH_12-1:0]     y_q, y_d;
   logic [DATA_WIDTH_12-1:0]     pixel_q, pixel_d;
   logic [DATA_WIDTH_12-1:0]     ox_q, ox_d;
   logic [DATA_WIDTH_12-1:0]     oy_q, oy_d;
   logic                         valid_q, valid_d;
   logic                         end_row_q, end_row_d;
   logic                         end_frame_q, end_frame_d;
   logic [FRAME_COUNT_WIDTH-1:0] fcnt_q, fcnt_d;
   logic                         underrun_q, underrun_d;
   logic                         overflow_q, overflow_d;

   // frame_start masks both FIFO ports so the flush wins over same-cycle traffic.
   assign pop  = pixel_request && !fifo_empty && !frame_start;
   assign push = wr_en && !frame_start;

   sync_fifo #(
      .WIDTH      (DATA_WIDTH_12),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk     (clk_os),
      .rst_n   (reset_os),
      .flush   (frame_start),
      .wr_en   (push),
      .wr_data (wr_pixel),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      pixel_d     = pixel_q;
      ox_d        = ox_q;
      oy_d        = oy_q;
      valid_d     = 1'b0;
      end_row_d   = end_row_q;
      end_frame_d = end_frame_q;
      fcnt_d      = fcnt_q;
      underrun_d  = underrun_q;
      overflow_d  = overflow_q;
      if (frame_start) begin
         x_d         = '0;
         y_d         = '0;
         ox_d        = '0;
         oy_d        = '0;
         end_row_d   = 1'b0;
         end_frame_d = 1'b0;
         underrun_d  = 1'b0;
         overflow_d  = 1'b0;
      end else begin
         if (wr_en && fifo_full && !pop) overflow_d = 1'b1;
         if (pixel_request) begin
            valid_d     = 1'b1;
            pixel_d     = fifo_empty ? '0 : fifo_rd_data;
            if (fifo_empty) underrun_d = 1'b1;
            ox_d        = x_q;
            oy_d        = y_q;
            end_row_d   = (x_q == X_LAST);
            end_frame_d = (x_q == X_LAST) && (y_q == Y_LAST);
            if (x_q == X_LAST) begin
               x_d = '0;
               if (y_q == Y_LAST) begin
                  y_d    = '0;
                  fcnt_d = fcnt_q + FRAME_COUNT_WIDTH'(1);
               end else begin
                  y_d = y_q + DATA_WIDTH_12'(1);
               end
            end else begin
               x_d = x_q + DATA_WIDTH_12'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_os or negedge reset_os) begin
      if (!reset_os) begin
         x_q         <= '0;
         y_q         <= '0;
         pixel_q     <= '0;
         ox_q        <= '0;
         oy_q        <= '0;
         valid_q     <= 1'b0;
         end_row_q   <= 1'b0;
         end_frame_q <= 1'b0;
         fcnt_q      <= '0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         pixel_q     <= pixel_d;
         ox_q        <= ox_d;
         oy_q        <= oy_d;
         valid_q     <= valid_d;
         end_row_q   <= end_row_d;
         end_frame_q <= end_frame_d;
         fcnt_q      <= fcnt_d;
         underrun_q  <= underrun_d;
         overflow_q  <= overflow_d;
      end
   end

   assign o_full        = fifo_full;
   assign o_fill_level  = fifo_count;
   assign o_pixel       = pixel_q;
   assign o_pixel_valid = valid_q;
   assign o_x           = ox_q;
   assign o_y           = oy_q;
   assign o_end_row     = end_row_q;
   assign o_end_frame   = end_frame_q;
   assign o_frame_count = fcnt_q;
   assign o_underrun    = underrun_q;
   assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Directed bench for pixel_frame_streamer: handshake, raster wrap, FIFO limits, flush and async reset.
module tb_pixel_frame_streamer;

   logic        clk_os = 1'b0;
   logic        reset_os;
   logic        frame_start;
   logic        wr_en;
   logic [11:0] wr_pixel;
   logic        o_full;
   logic [4:0]  o_fill_level;
   logic        pixel_request;
   logic [11:0] o_pixel;
   logic        o_pixel_valid;
   logic [11:0] o_x;
   logic [11:0] o_y;
   logic        o_end_row;
   logic        o_end_frame;
   logic [7:0]  o_frame_count;
   logic        o_underrun;
   logic        o_overflow;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned row_ends = 0;
   int unsigned frame_ends = 0;

   pixel_frame_streamer #(
      .DATA_WIDTH_12                (12),
      .FRAME_ORIGINAL_CAMERA_WIDTH  (100),
      .FRAME_ORIGINAL_CAMERA_HEIGHT (24),
      .FIFO_DEPTH                   (16),
      .FIFO_ADDR_WIDTH              (4),
      .FRAME_COUNT_WIDTH            (8)
   ) dut (
      .clk_os        (clk_os),
      .reset_os      (reset_os),
      .frame_start   (frame_start),
      .wr_en         (wr_en),
      .wr_pixel      (wr_pixel),
      .o_full        (o_full),
      .o_fill_level  (o_fill_level),
      .pixel_request (pixel_request),
      .o_pixel       (o_pixel),
      .o_pixel_valid (o_pixel_valid),
      .o_x           (o_x),
      .o_y           (o_y),
      .o_end_row     (o_end_row),
      .o_end_frame   (o_end_frame),
      .o_frame_count (o_frame_count),
      .o_underrun    (o_underrun),
      .o_overflow    (o_overflow)
   );

   always #5 clk_os = ~clk_os;

   task automatic tick();
      @(posedge clk_os);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [11:0] pix, input logic vld,
                          input logic [11:0] x, input logic [11:0] y);
      chk({tag, ".pixel"}, 32'(o_pixel), 32'(pix));
      chk({tag, ".valid"}, 32'(o_pixel_valid), 32'(vld));
      chk({tag, ".x"}, 32'(o_x), 32'(x));
      chk({tag, ".y"}, 32'(o_y), 32'(y));
   endtask

   task automatic write_px(input logic [11:0] v);
      wr_en    = 1'b1;
      wr_pixel = v;
      tick();
      wr_en    = 1'b0;
   endtask

   task automatic request_once();
      pixel_request = 1'b1;
      tick();
      pixel_request = 1'b0;
   endtask

   initial begin
      reset_os      = 1'b0;
      frame_start   = 1'b0;
      wr_en         = 1'b0;
      wr_pixel      = '0;
      pixel_request = 1'b0;
      #23;
      chk("rst.pixel", 32'(o_pixel), 0);
      chk("rst.valid", 32'(o_pixel_valid), 0);
      chk("rst.fill", 32'(o_fill_level), 0);
      chk("rst.full", 32'(o_full), 0);
      chk("rst.fcnt", 32'(o_frame_count), 0);
      chk("rst.flags", 32'({o_underrun, o_overflow, o_end_row, o_end_frame}), 0);
      tick();
      reset_os = 1'b1;
      tick();

      // Three pixels, three single requests
      write_px(12'h011);
      write_px(12'h022);
      write_px(12'h033);
      chk("t1.fill3", 32'(o_fill_level), 3);
      request_once();
      chk_out("t1.r0", 12'h011, 1'b1, 12'd0, 12'd0);
      chk("t1.fill2", 32'(o_fill_level), 2);
      tick();
      chk("t1.valid_drop", 32'(o_pixel_valid), 0);
      chk("t1.pixel_hold", 32'(o_pixel), 32'h011);
      request_once();
      chk_out("t1.r1", 12'h022, 1'b1, 12'd1, 12'd0);
      request_once();
      chk_out("t1.r2", 12'h033, 1'b1, 12'd2, 12'd0);
      chk("t1.fill0", 32'(o_fill_level), 0);
      chk("t1.underrun0", 32'(o_underrun), 0);

      // Starved request: zero pixel, strobe, coordinate advance, sticky flag
      request_once();
      chk_out("t4.starve", 12'h000, 1'b1, 12'd3, 12'd0);
      chk("t4.underrun", 32'(o_underrun), 1);
      tick();
      tick();
      chk("t4.underrun_sticky", 32'(o_underrun), 1);

      // Realign, then stream a full frame back-to-back with one entry in flight
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("fs1.underrun", 32'(o_underrun), 0);
      chk("fs1.x", 32'(o_x), 0);
      write_px(12'h000);
      for (int k = 0; k < 2400; k++) begin
         wr_en         = 1'b1;
         wr_pixel      = 12'(k + 1);
         pixel_request = 1'b1;
         tick();
         chk_out("t3.px", 12'(k), 1'b1, 12'(k % 100), 12'(k / 100));
         chk("t3.end_row", 32'(o_end_row), 32'((k % 100) == 99));
         chk("t3.end_frame", 32'(o_end_frame), 32'(k == 2399));
         if (o_end_row) row_ends++;
         if (o_end_frame) frame_ends++;
      end
      wr_en         = 1'b0;
      pixel_request = 1'b0;
      chk("t3.row_ends", row_ends, 24);
      chk("t3.frame_ends", frame_ends, 1);
      chk("t3.fcnt", 32'(o_frame_count), 1);
      chk("t3.fill", 32'(o_fill_level), 1);
      chk("t3.underrun", 32'(o_underrun), 0);
      request_once();
      chk_out("t3.wrap", 12'h960, 1'b1, 12'd0, 12'd0);
      chk("t3.wrap_end_frame", 32'(o_end_frame), 0);

      // Fill to depth, overflow drop, then write+read while full
      for (int i = 0; i < 16; i++) write_px(12'(12'h100 + i));
      chk("t5.full", 32'(o_full), 1);
      chk("t5.fill16", 32'(o_fill_level), 16);
      chk("t5.ovf0", 32'(o_overflow), 0);
      write_px(12'hABC);
      chk("t5.ovf1", 32'(o_overflow), 1);
      chk("t5.fill_hold", 32'(o_fill_level), 16);
      wr_en         = 1'b1;
      wr_pixel      = 12'h200;
      pixel_request = 1'b1;
      tick();
      wr_en         = 1'b0;
      pixel_request = 1'b0;
      chk_out("t5.rw_full", 12'h100, 1'b1, 12'd1, 12'd0);
      chk("t5.fill_rw", 32'(o_fill_level), 16);
      chk("t5.ovf_sticky", 32'(o_overflow), 1);
      for (int i = 1; i < 16; i++) begin
         request_once();
         chk("t5.drain", 32'(o_pixel), 32'(12'h100 + i));
      end
      request_once();
      chk_out("t5.drain_last", 12'h200, 1'b1, 12'd17, 12'd0);
      chk("t5.empty", 32'(o_fill_level), 0);

      // Walk to (37,5) starving, buffer 4, then flush with competing traffic
      pixel_request = 1'b1;
      for (int i = 0; i < 519; i++) tick();
      pixel_request = 1'b0;
      chk_out("t6.pos", 12'h000, 1'b1, 12'd36, 12'd5);
      chk("t6.underrun", 32'(o_underrun), 1);
      for (int i = 0; i < 4; i++) write_px(12'(12'h300 + i));
      chk("t6.fill4", 32'(o_fill_level), 4);
      frame_start   = 1'b1;
      wr_en         = 1'b1;
      wr_pixel      = 12'h7FF;
      pixel_request = 1'b1;
      tick();
      frame_start   = 1'b0;
      wr_en         = 1'b0;
      pixel_request = 1'b0;
      chk("t6.fill0", 32'(o_fill_level), 0);
      chk("t6.flags", 32'({o_underrun, o_overflow, o_end_row, o_end_frame, o_pixel_valid}), 0);
      chk("t6.xy", 32'({o_x, o_y}), 0);
      chk("t6.fcnt", 32'(o_frame_count), 1);
      write_px(12'h5A5);
      request_once();
      chk_out("t6.first", 12'h5A5, 1'b1, 12'd0, 12'd0);

      // Asynchronous reset mid-stream
      write_px(12'h0F0);
      write_px(12'h0F1);
      wr_en         = 1'b1;
      wr_pixel      = 12'h0F2;
      pixel_request = 1'b1;
      tick();
      chk("t7.pre_valid", 32'(o_pixel_valid), 1);
      #2;
      reset_os = 1'b0;
      #1;
      chk("t7.pixel", 32'(o_pixel), 0);
      chk("t7.valid", 32'(o_pixel_valid), 0);
      chk("t7.xy", 32'({o_x, o_y}), 0);
      chk("t7.fill", 32'(o_fill_level), 0);
      chk("t7.fcnt", 32'(o_frame_count), 0);
      chk("t7.flags", 32'({o_full, o_underrun, o_overflow, o_end_row, o_end_frame}), 0);
      wr_en         = 1'b0;
      pixel_request = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
